dmem_initiator: RTL and testbench

- Initiator side of the data-memory port protocol: read, write, byte_enable, address, wdata out; resp and rdata in.
- Sits between the pipeline's load/store stage and a dual-port memory's data port, either the simulation memory model or a cache.
- Accepts one RV32 load/store at a time from the core and converts it into a single word-aligned memory transaction with byte enables.
- Holds the transaction until resp, then returns sign- or zero-extended load data, or a store completion, to the core.

---
 rtl/dmem_initiator_if.sv | 21 ++
 rtl/dmem_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_initiator.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_initiator_if.sv
// Data-memory port bundle between the load/store initiator and a memory or cache.
// master = initiator (drives strobes, address, data); slave = memory (drives resp, rdata).
interface dmem_initiator_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
        input  dmem_resp, dmem_rdata
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
        output dmem_resp, dmem_rdata
    );
endinterface

// File: rtl/dmem_initiator.sv
// Turns one RV32 load/store into a word-aligned memory transaction; rsp 2 cycles after accept with zero-wait memory.
// Backpressure: req_ready only in IDLE; one request in flight. Optional response timeout: DMEM_TIMEOUT_EN.
module dmem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    dmem_initiator_if.master dmem
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("dmem_initiator: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
`ifdef DMEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    logic [31:0] lane;
    logic [31:0] load_data;

    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b100:  ok = !we;
            3'b001:  ok = !a[0];
            3'b101:  ok = !we && !a[0];
            3'b010:  ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = 4'b0011 << {a[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Align the addressed byte/half to bit 0, then extend by width code.
    always_comb begin
        lane = dmem.dmem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_data = {24'h0, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'h0, lane[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        dmem_read_d  = dmem_read_q;
        dmem_write_d = dmem_write_q;
        be_d         = be_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = 32'h0;
        rsp_error_d  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    if (req_legal(req_we, req_funct3, req_addr[1:0])) begin
                        state_d      = BUSY;
                        dmem_read_d  = !req_we;
                        dmem_write_d = req_we;
                        be_d         = lane_mask(req_funct3, req_addr[1:0]);
                        address_d    = {req_addr[31:2], 2'b00};
                        wdata_d      = lane_data(req_funct3, req_wdata);
`ifdef DMEM_TIMEOUT_EN
                        cnt_d        = 16'h0;
`endif
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmem_resp) begin
                    state_d      = RESP;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    be_d         = 4'h0;
                    address_d    = 32'h0;
                    wdata_d      = 32'h0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = we_q ? 32'h0 : load_data;
                end
`ifdef DMEM_TIMEOUT_EN
                // A response arriving on the final allowed cycle still completes normally.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = RESP;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    be_d         = 4'h0;
                    address_d    = 32'h0;
                    wdata_d      = 32'h0;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            be_q         <= 4'h0;
            address_q    <= 32'h0;
            wdata_q      <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_error_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            be_q         <= be_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready             = (state_q == IDLE);
    assign rsp_valid             = rsp_valid_q;
    assign rsp_rdata             = rsp_rdata_q;
    assign rsp_error             = rsp_error_q;
    assign dmem.dmem_read        = dmem_read_q;
    assign dmem.dmem_write       = dmem_write_q;
    assign dmem.dmem_byte_enable = be_q;
    assign dmem.dmem_address     = address_q;
    assign dmem.dmem_wdata       = wdata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator against a small word memory with programmable response stall.
module tb_dmem_initiator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    dmem_initiator_if dif ();

    dmem_initiator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .dmem       (dif.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    int unsigned stall = 0;
    int unsigned wait_cnt = 0;
    logic        strobe;

    assign strobe         = dif.dmem_read | dif.dmem_write;
    assign dif.dmem_resp  = strobe && (wait_cnt >= stall);
    assign dif.dmem_rdata = mem[dif.dmem_address[9:2]];

    always @(posedge clk) begin
        if (strobe && !dif.dmem_resp) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
        if (dif.dmem_write && dif.dmem_resp) begin
            for (int i = 0; i < 4; i++)
                if (dif.dmem_byte_enable[i])
                    mem[dif.dmem_address[9:2]][8*i +: 8] <= dif.dmem_wdata[8*i +: 8];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          r_lat, r_busy;
    logic        r_done, r_stable, r_rd, r_wr, r_err;
    logic [31:0] r_rdata, r_adr, r_wd;
    logic [3:0]  r_be;

    // Issue one request, follow it to rsp_valid, and record what the memory port showed.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        r_lat = 1; r_busy = 0; r_done = 1'b0; r_stable = 1'b1; r_rd = 1'b0; r_wr = 1'b0;
        r_rdata = 32'hx; r_err = 1'bx; r_be = 4'h0; r_adr = 32'h0; r_wd = 32'h0;
        for (int i = 0; i < 200 && !r_done; i++) begin
            if (strobe) begin
                if (r_busy == 0) begin
                    r_be = dif.dmem_byte_enable; r_adr = dif.dmem_address; r_wd = dif.dmem_wdata;
                end else if (r_be !== dif.dmem_byte_enable || r_adr !== dif.dmem_address ||
                             r_wd !== dif.dmem_wdata || (r_rd | r_wr) !== strobe) begin
                    r_stable = 1'b0;
                end
                r_busy++;
            end
            r_rd = r_rd | dif.dmem_read;
            r_wr = r_wr | dif.dmem_write;
            if (rsp_valid) begin
                r_done = 1'b1; r_rdata = rsp_rdata; r_err = rsp_error;
            end else begin
                r_lat++;
                @(negedge clk);
            end
        end
        chk("rsp_seen", r_done, 1'b1);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 1'b0);
        chk("ready_after", req_ready, 1'b1);
    endtask

    logic saw_rsp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h80FF_7F01;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        chk("rst_read", dif.dmem_read, 1'b0);
        chk("rst_write", dif.dmem_write, 1'b0);
        chk("rst_be", dif.dmem_byte_enable, 4'h0);
        chk("rst_addr", dif.dmem_address, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_error}, 2'b00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);

        run(1'b0, 3'b000, 32'h103, 32'h0);            // LB
        chk("lb_lat", r_lat, 2);
        chk("lb_addr", r_adr, 32'h100);
        chk("lb_be", r_be, 4'b1000);
        chk("lb_rd", {r_rd, r_wr}, 2'b10);
        chk("lb_data", r_rdata, 32'hFFFF_FF80);
        chk("lb_err", r_err, 1'b0);

        run(1'b0, 3'b100, 32'h103, 32'h0);            // LBU
        chk("lbu_data", r_rdata, 32'h0000_0080);

        run(1'b0, 3'b101, 32'h102, 32'h0);            // LHU
        chk("lhu_be", r_be, 4'b1100);
        chk("lhu_data", r_rdata, 32'h0000_80FF);

        run(1'b0, 3'b001, 32'h102, 32'h0);            // LH
        chk("lh_data", r_rdata, 32'hFFFF_80FF);

        run(1'b1, 3'b000, 32'h201, 32'h1234_56AB);    // SB
        chk("sb_strobes", {r_rd, r_wr}, 2'b01);
        chk("sb_be", r_be, 4'b0010);
        chk("sb_wdata", r_wd, 32'hABAB_ABAB);
        chk("sb_rsp", {r_err, r_rdata}, 33'h0);

        run(1'b0, 3'b010, 32'h200, 32'h0);            // LW
        chk("lw_after_sb", r_rdata, 32'h0000_AB00);

        run(1'b1, 3'b001, 32'h206, 32'h0000_CAFE);    // SH
        chk("sh_be", r_be, 4'b1100);
        chk("sh_wdata", r_wd, 32'hCAFE_CAFE);

        run(1'b0, 3'b010, 32'h102, 32'h0);            // misaligned LW
        chk("mis_strobe", {r_rd, r_wr}, 2'b00);
        chk("mis_lat", r_lat, 1);
        chk("mis_err", r_err, 1'b1);
        chk("mis_data", r_rdata, 32'h0);

        run(1'b1, 3'b100, 32'h200, 32'h0);            // store with BU code
        chk("sbu_strobe", {r_rd, r_wr}, 2'b00);
        chk("sbu_err", r_err, 1'b1);

        run(1'b0, 3'b011, 32'h100, 32'h0);            // undefined width code
        chk("f3_err", r_err, 1'b1);

        stall = 5;
        run(1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF);    // SW with 5 wait cycles
        chk("stall_busy", r_busy, 6);
        chk("stall_stable", r_stable, 1'b1);
        chk("stall_lat", r_lat, 7);
        chk("stall_err", r_err, 1'b0);
        chk("stall_wdata", r_wd, 32'hDEAD_BEEF);
        stall = 0;
        run(1'b0, 3'b010, 32'h204, 32'h0);
        chk("sw_readback", r_rdata, 32'hDEAD_BEEF);

`ifdef DMEM_TIMEOUT_EN
        stall = 1000;
        run(1'b0, 3'b010, 32'h300, 32'h0);
        chk("to_busy", r_busy, 64);
        chk("to_lat", r_lat, 65);
        chk("to_err", r_err, 1'b1);
        chk("to_data", r_rdata, 32'h0);
        stall = 0;
`endif

        // Reset while a load is stalled in BUSY.
        stall = 50;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rb_busy_read", dif.dmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rb_read", dif.dmem_read, 1'b0);
        chk("rb_be", dif.dmem_byte_enable, 4'h0);
        chk("rb_addr", dif.dmem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            saw_rsp = saw_rsp | rsp_valid;
            @(negedge clk);
        end
        chk("rb_no_rsp", saw_rsp, 1'b0);
        chk("rb_ready", req_ready, 1'b1);
        chk("rb_idle_read", dif.dmem_read, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end
endmodule
